// File: rtl/boundary_receiver_if.sv
// Handshake bundle for the Hermes boundary receiver: mesh-side flit input
// with credit flow control, and consumer-side payload stream.
interface boundary_receiver_if #(
  parameter int FLIT_SIZE = 32
) ();

  logic                 rx_i;
  logic [FLIT_SIZE-1:0] data_i;
  logic                 credit_o;
  logic                 out_valid_o;
  logic [FLIT_SIZE-1:0] out_data_o;
  logic                 out_last_o;
  logic                 out_ready_i;

  // Mesh edge plus payload consumer: drives flits and pops the FIFO.
  modport master (
    output rx_i, data_i, out_ready_i,
    input  credit_o, out_valid_o, out_data_o, out_last_o
  );

  // The receiver itself.
  modport slave (
    input  rx_i, data_i, out_ready_i,
    output credit_o, out_valid_o, out_data_o, out_last_o
  );

endinterface

// File: rtl/boundary_receiver.sv
// Hermes boundary receiver: parses header/size/payload packets arriving at a
// mesh edge port, keeps payloads addressed to LOCAL_ADDR in a FIFO, discards
// the rest, and counts delivered and dropped packets.
module boundary_receiver #(
  parameter int          FLIT_SIZE  = 32,
  parameter logic [15:0] LOCAL_ADDR = 16'h0000,
  parameter int          DEPTH      = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  boundary_receiver_if.slave  bus,
  output logic [15:0]         pkt_cnt_o,
  output logic [15:0]         drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {HEADER, SIZE, PAYLOAD, DROP} state_t;
  typedef logic [FLIT_SIZE:0] entry_t;  // {last, data}

  state_t      state;
  logic [15:0] remaining;
  logic        mismatch;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];

  logic        full;
  logic        empty;
  logic        xfer;
  logic        push;
  logic        pop;
  logic [15:0] field;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Credit is withheld only while payload is being stored into a full FIFO;
  // a same-cycle pop does not free a slot for the incoming flit.
  assign bus.credit_o = rst_ni && ((state != PAYLOAD) || !full);

  assign field = bus.data_i[15:0];
  assign xfer  = bus.rx_i && bus.credit_o;
  assign push  = xfer && (state == PAYLOAD);
  assign pop   = !empty && bus.out_ready_i;

  assign bus.out_valid_o                   = !empty;
  assign {bus.out_last_o, bus.out_data_o}  = mem[rd_ptr[AW-1:0]];

  // Packet parser: walks header, size and payload/drop phases and counts
  // the outcome of each packet on its final flit.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= HEADER;
      remaining  <= '0;
      mismatch   <= 1'b0;
      pkt_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else if (xfer) begin
      case (state)
        HEADER: begin
          mismatch <= (field != LOCAL_ADDR);
          state    <= SIZE;
        end
        SIZE: begin
          remaining <= field;
          if (field == 16'd0) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
            state      <= HEADER;
          end else if (mismatch) begin
            state <= DROP;
          end else begin
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            pkt_cnt_o <= pkt_cnt_o + 16'd1;
            state     <= HEADER;
          end
        end
        DROP: begin
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
            state      <= HEADER;
          end
        end
        default: state <= HEADER;
      endcase
    end
  end

  // FIFO pointers: reset empties the FIFO, discarding any partial packet.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage write, tagging the packet's final payload flit.
  // NOTE: the storage array is deliberately not reset; entries are only
  // observed behind valid pointers, so clearing them would be pure cost.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {(remaining == 16'd1), bus.data_i};
  end

endmodule

// File: tb/tb_boundary_receiver.sv
// Self-checking bench for boundary_receiver: a packet-level reference model
// (parse position, expected-output queue, counters) is compared against the
// DUT every cycle; directed scenarios add literal expectations.
module tb_boundary_receiver;

  localparam int          FLIT_SIZE  = 32;
  localparam logic [15:0] LOCAL_ADDR = 16'h0000;
  localparam int          DEPTH      = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  boundary_receiver_if #(.FLIT_SIZE(FLIT_SIZE)) bus ();

  boundary_receiver #(
    .FLIT_SIZE (FLIT_SIZE),
    .LOCAL_ADDR(LOCAL_ADDR),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
    .pkt_cnt_o (pkt_cnt),
    .drop_cnt_o(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position within the current packet (0 header,
  // 1 size, >=2 body), whether the packet is foreign, flits left, and the
  // queue of payload entries {last, data} the consumer must still see.
  int                   m_pos = 0;
  bit                   m_mis = 1'b0;
  int                   m_left = 0;
  logic [FLIT_SIZE:0]   m_q[$];
  logic [15:0]          m_pkt = '0;
  logic [15:0]          m_drop = '0;
  logic [FLIT_SIZE:0]   obs[$];   // entries the DUT actually handed out
  bit                   last_xfer;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_credit();
    if (!rst_n) return 1'b0;
    if (m_pos >= 2 && !m_mis) return (m_q.size() < DEPTH);
    return 1'b1;
  endfunction

  // One clock cycle: compare DUT against model, then advance the model
  // across the rising edge using the inputs currently driven.
  task automatic step();
    bit                   exp_credit;
    bit                   xfer;
    bit                   pop;
    logic [FLIT_SIZE-1:0] d;
    #1;
    exp_credit = m_credit();
    check("credit", 64'(bus.credit_o), 64'(exp_credit));
    check("out_valid", 64'(bus.out_valid_o), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("out_data", 64'(bus.out_data_o), 64'(m_q[0][FLIT_SIZE-1:0]));
      check("out_last", 64'(bus.out_last_o), 64'(m_q[0][FLIT_SIZE]));
    end
    check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    xfer = bus.rx_i && exp_credit;
    pop  = rst_n && (m_q.size() != 0) && bus.out_ready_i;
    d    = bus.data_i;
    if (rst_n && bus.out_valid_o && bus.out_ready_i)
      obs.push_back({bus.out_last_o, bus.out_data_o});
    @(posedge clk);
    last_xfer = xfer;
    if (!rst_n) begin
      m_pos = 0; m_mis = 1'b0; m_left = 0;
      m_q.delete(); obs.delete();
      m_pkt = '0; m_drop = '0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (xfer) begin
        if (m_pos == 0) begin
          m_mis = (d[15:0] != LOCAL_ADDR);
          m_pos = 1;
        end else if (m_pos == 1) begin
          m_left = int'(d[15:0]);
          if (m_left == 0) begin
            m_drop = m_drop + 16'd1;
            m_pos  = 0;
          end else begin
            m_pos = 2;
          end
        end else begin
          if (!m_mis) m_q.push_back({(m_left == 1), d});
          m_left--;
          if (m_left == 0) begin
            if (m_mis) m_drop = m_drop + 16'd1;
            else       m_pkt  = m_pkt + 16'd1;
            m_pos = 0;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  // Offer one flit until accepted (bounded); reports how many cycles it took.
  task automatic send(input logic [FLIT_SIZE-1:0] d, output int tries);
    bus.rx_i   = 1'b1;
    bus.data_i = d;
    tries = 0;
    do begin
      step();
      tries++;
    end while (!last_xfer && tries < 200);
    check("send_accept", 64'(last_xfer), 64'd1);
    bus.rx_i = 1'b0;
  endtask

  task automatic send1(input logic [FLIT_SIZE-1:0] d);
    int t;
    send(d, t);
  endtask

  task automatic idle(input int n);
    bus.rx_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    bus.rx_i = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [FLIT_SIZE-1:0] gen[$];

  task automatic build_packet();
    logic [15:0] sz;
    logic [15:0] hi;
    hi = 16'($urandom);
    if ($urandom_range(1) == 0) gen.push_back({hi, LOCAL_ADDR});
    else                        gen.push_back($urandom);
    sz = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom_range(12, 1));
    gen.push_back({16'($urandom), sz});
    for (int i = 0; i < int'(sz); i++) gen.push_back($urandom);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.rx_i = 1'b0;
    bus.data_i = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_credit", 64'(bus.credit_o), 64'd1);
    check("rst_pkt", 64'(pkt_cnt), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    @(negedge clk);

    // Local packet of three payload flits.
    do_reset();
    bus.out_ready_i = 1'b1;
    send1(32'h0000_0000); send1(32'h0000_0003);
    send1(32'hAAAA_0001); send1(32'hBBBB_0002); send1(32'hCCCC_0003);
    idle(4);
    check("s1_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      check("s1_a", 64'(obs[0]), {31'd0, 1'b0, 32'hAAAA_0001});
      check("s1_b", 64'(obs[1]), {31'd0, 1'b0, 32'hBBBB_0002});
      check("s1_c", 64'(obs[2]), {31'd0, 1'b1, 32'hCCCC_0003});
    end
    check("s1_pkt", 64'(pkt_cnt), 64'd1);

    // Foreign packet is dropped with credit held high.
    do_reset();
    send1(32'h0000_0101); send1(32'h0000_0002);
    send(32'h1111_1111, t); check("s2_credit_a", 64'(t), 64'd1);
    send(32'h2222_2222, t); check("s2_credit_b", 64'(t), 64'd1);
    idle(2);
    check("s2_nopush", 64'(obs.size()), 64'd0);
    check("s2_valid", 64'(bus.out_valid_o), 64'd0);
    check("s2_drop", 64'(drop_cnt), 64'd1);

    // Local packet with size zero.
    do_reset();
    send1(32'h0000_0000); send1(32'h0000_0000);
    idle(2);
    check("s3_drop", 64'(drop_cnt), 64'd1);
    check("s3_valid", 64'(bus.out_valid_o), 64'd0);
    check("s3_pkt", 64'(pkt_cnt), 64'd0);

    // Size 10 against a stalled consumer: FIFO fills, then drains in order.
    do_reset();
    bus.out_ready_i = 1'b0;
    send1(32'h0000_0000); send1(32'h0000_000A);
    for (int i = 0; i < 8; i++) send1(32'h5000_0000 + 32'(i));
    bus.rx_i = 1'b1;
    bus.data_i = 32'h5000_0008;
    #1;
    check("s4_full_credit", 64'(bus.credit_o), 64'd0);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    send1(32'h5000_0008); send1(32'h5000_0009);
    idle(12);
    check("s4_count", 64'(obs.size()), 64'd10);
    for (int i = 0; i < 10 && i < obs.size(); i++)
      check($sformatf("s4_flit%0d", i), 64'(obs[i]), {31'd0, (i == 9), 32'h5000_0000 + 32'(i)});
    check("s4_pkt", 64'(pkt_cnt), 64'd1);

    // Back-to-back packets, sizes 1 and 2, no gap.
    do_reset();
    send1(32'h0000_0000); send1(32'h0000_0001); send1(32'h7000_0001);
    send1(32'h0000_0000); send1(32'h0000_0002); send1(32'h7000_0002); send1(32'h7000_0003);
    idle(4);
    check("s5_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      check("s5_f1", 64'(obs[0]), {31'd0, 1'b1, 32'h7000_0001});
      check("s5_f2", 64'(obs[1]), {31'd0, 1'b0, 32'h7000_0002});
      check("s5_f3", 64'(obs[2]), {31'd0, 1'b1, 32'h7000_0003});
    end
    check("s5_pkt", 64'(pkt_cnt), 64'd2);

    // Reset in the middle of a packet, then a clean packet.
    do_reset();
    bus.out_ready_i = 1'b0;
    send1(32'h0000_0000); send1(32'h0000_0005);
    send1(32'h9000_0000); send1(32'h9000_0001);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("s6_valid", 64'(bus.out_valid_o), 64'd0);
    check("s6_pkt", 64'(pkt_cnt), 64'd0);
    check("s6_drop", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    send1(32'h0000_0000); send1(32'h0000_0002);
    send1(32'h9100_0000); send1(32'h9100_0001);
    idle(3);
    check("s6_count", 64'(obs.size()), 64'd2);
    if (obs.size() == 2) begin
      check("s6_f1", 64'(obs[0]), {31'd0, 1'b0, 32'h9100_0000});
      check("s6_f2", 64'(obs[1]), {31'd0, 1'b1, 32'h9100_0001});
    end
    check("s6_pkt", 64'(pkt_cnt), 64'd1);

    // Randomized traffic, stalls and occasional resets against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (gen.size() == 0) build_packet();
      bus.rx_i        = ($urandom_range(3) != 0);
      bus.data_i      = bus.rx_i ? gen[0] : $urandom;
      bus.out_ready_i = ($urandom_range(9) < 7);
      rst_n           = ($urandom_range(499) != 0);
      step();
      if (!rst_n) gen.delete();
      else if (last_xfer) void'(gen.pop_front());
      rst_n = 1'b1;
    end
    bus.out_ready_i = 1'b1;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boundary_receiver.md
BOUNDARY_RECEIVER -- requirements
Module: boundary_receiver

Interface
REQ-001 The block SHALL have parameter FLIT_SIZE, default 32, meaning Hermes flit width in bits.
REQ-002 The block SHALL have parameter LOCAL_ADDR, default 16'h0000, meaning the boundary address this receiver accepts.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning payload FIFO entries (power of two, >=2).
REQ-004 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1, with reset synchronous and active-low.
REQ-006 The block SHALL have port rx_i, input, 1, meaning a flit from the mesh edge port is valid.
REQ-007 The block SHALL have port data_i, input, FLIT_SIZE, meaning the flit from the mesh.
REQ-008 The block SHALL have port credit_o, output, 1, meaning the receiver accepts a flit this cycle; a transfer occurs when rx_i and credit_o are both 1.
REQ-009 The block SHALL have port out_valid_o, output, 1, meaning the payload flit at the FIFO head is valid.
REQ-010 The block SHALL have port out_data_o, output, FLIT_SIZE, meaning the payload flit at the FIFO head.
REQ-011 The block SHALL have port out_last_o, output, 1, meaning the head flit is the final flit of its packet.
REQ-012 The block SHALL have port out_ready_i, input, 1, meaning the consumer pops the head when out_valid_o is 1.
REQ-013 The block SHALL have port pkt_cnt_o, output, 16, counting delivered packets.
REQ-014 The block SHALL have port drop_cnt_o, output, 16, counting dropped packets.

Function
REQ-015 The block SHALL parse each packet as: flit 0 header (target in data_i[15:0]), flit 1 size (payload flit count in data_i[15:0]), then that many payload flits.
REQ-016 The FSM SHALL have the states HEADER, SIZE, PAYLOAD and DROP.
REQ-017 In HEADER, a transfer SHALL latch mismatch = (data_i[15:0] != LOCAL_ADDR) and move to SIZE.
REQ-018 In SIZE, a transfer SHALL load the remaining counter with data_i[15:0]; size 0 SHALL go to HEADER and increment drop_cnt_o; a mismatch SHALL go to DROP; otherwise the FSM SHALL go to PAYLOAD.
REQ-019 In PAYLOAD, each transfer SHALL push {last = (remaining == 1), data_i} into the FIFO and decrement remaining; the last push SHALL return the FSM to HEADER and increment pkt_cnt_o in the same cycle.
REQ-020 In DROP, each transfer SHALL be discarded and decrement remaining; the final flit SHALL return the FSM to HEADER and increment drop_cnt_o.
REQ-021 credit_o SHALL be combinational: 1 in HEADER, SIZE and DROP; in PAYLOAD it SHALL equal !full; it SHALL be 0 whenever rst_ni is 0.
REQ-022 When the FIFO is full, no push SHALL occur even if a pop occurs in the same cycle (credit_o is deasserted, no bypass).
REQ-023 When the FIFO is neither full nor empty, a simultaneous push and pop SHALL both occur and the occupancy SHALL stay unchanged.
REQ-024 out_valid_o SHALL equal !empty; out_data_o and out_last_o SHALL show the head entry whenever out_valid_o is 1.
REQ-025 out_data_o and out_last_o SHALL be stable while out_valid_o is 1 and out_ready_i is 0.
REQ-026 A pop SHALL occur only when out_valid_o and out_ready_i are both 1; out_ready_i SHALL be ignored when the FIFO is empty.
REQ-027 Minimum latency SHALL be 1 cycle: a payload flit accepted at edge N is visible on out_* after edge N.
REQ-028 The FIFO pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full and empty SHALL derive from the MSB and the index.
REQ-029 pkt_cnt_o and drop_cnt_o SHALL wrap from 16'hFFFF to 0.
REQ-030 Payload size SHALL use 16 bits unsigned; bits above 15 of the size flit SHALL be ignored.
REQ-031 Back-to-back packets SHALL need no idle cycle: a header may transfer on the cycle after the previous last flit.

Reset
REQ-032 On a rising edge with rst_ni = 0, the block SHALL set: FSM = HEADER, FIFO empty (out_valid_o = 0), remaining = 0, mismatch = 0, pkt_cnt_o = 0, drop_cnt_o = 0.
REQ-033 A reset mid-packet SHALL discard the partial packet and all FIFO contents without counting either; parsing SHALL restart at HEADER.
REQ-034 out_data_o and out_last_o SHALL be don't-care while out_valid_o is 0.

Verification
REQ-035 The bench SHALL cover: header 0x0000, size 3, payload A,B,C with out_ready_i = 1 -> out A,B,C with out_last_o only on C, and pkt_cnt_o = 1.
REQ-036 The bench SHALL cover: header 0x0101, size 2 -> credit_o stays 1, no FIFO push, and drop_cnt_o = 1.
REQ-037 The bench SHALL cover: header 0x0000, size 0 -> FSM back in HEADER, drop_cnt_o = 1, and out_valid_o stays 0.
REQ-038 The bench SHALL cover: size 10 with out_ready_i = 0 -> after 8 payload flits credit_o = 0; then out_ready_i = 1 -> all 10 flits delivered in order.
REQ-039 The bench SHALL cover: two back-to-back packets (sizes 1 and 2) with no gap -> 3 output flits with out_last_o on flits 1 and 3, and pkt_cnt_o = 2.
REQ-040 The bench SHALL cover: rst_ni = 0 after 2 of 5 payload flits -> out_valid_o = 0 and counters 0; a following valid packet is received correctly.
